// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, opclass encoding, ALU control
// codes, immediate formats, the decode control bundle and ALU helpers.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // JALR shares the jump class; its ALU code tells it apart from JAL.
    typedef enum logic [2:0] {
        OC_R      = 3'd0,
        OC_IALU   = 3'd1,
        OC_LOAD   = 3'd2,
        OC_STORE  = 3'd3,
        OC_BRANCH = 3'd4,
        OC_LUI    = 3'd5,
        OC_AUIPC  = 3'd6,
        OC_JAL    = 3'd7
    } opclass_t;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_BEQ    = 5'd10,
        ALU_BNE    = 5'd11,
        ALU_BLT    = 5'd12,
        ALU_BGE    = 5'd13,
        ALU_BLTU   = 5'd14,
        ALU_BGEU   = 5'd15,
        ALU_PASSB  = 5'd16,
        ALU_JAL    = 5'd17,
        ALU_JALR   = 5'd18,
        ALU_MUL    = 5'd19,
        ALU_MULH   = 5'd20,
        ALU_MULHSU = 5'd21,
        ALU_MULHU  = 5'd22,
        ALU_DIV    = 5'd23,
        ALU_DIVU   = 5'd24,
        ALU_REM    = 5'd25,
        ALU_REMU   = 5'd26
    } alu_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        alu_t       alu;
        opclass_t   opclass;
        logic       reg_write;
        logic       mem_write;
        logic       illegal;
    } id_ctrl_t;

    // alt selects SUB over ADD and SRA over SRL.
    function automatic alu_t alu_arith(input logic [2:0] f3,
                                       input logic alt);
        alu_t r;
        unique case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic alu_t alu_branch(input logic [2:0] f3);
        alu_t r;
        unique case (f3)
            3'b001:  r = ALU_BNE;
            3'b100:  r = ALU_BLT;
            3'b101:  r = ALU_BGE;
            3'b110:  r = ALU_BLTU;
            3'b111:  r = ALU_BGEU;
            default: r = ALU_BEQ;
        endcase
        return r;
    endfunction

    function automatic alu_t alu_mext(input logic [2:0] f3);
        alu_t r;
        unique case (f3)
            3'b000:  r = ALU_MUL;
            3'b001:  r = ALU_MULH;
            3'b010:  r = ALU_MULHSU;
            3'b011:  r = ALU_MULHU;
            3'b100:  r = ALU_DIV;
            3'b101:  r = ALU_DIVU;
            3'b110:  r = ALU_REM;
            default: r = ALU_REMU;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator, sign-extends to XLEN.
// Ports: instr[31:7] raw bits, fmt immediate format, imm result.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        unique case (fmt)
            IMM_I: imm = XLEN'($signed(instr[31:20]));
            IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B: imm = XLEN'($signed({instr[31], instr[7],
                                        instr[30:25], instr[11:8],
                                        1'b0}));
            IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J: imm = XLEN'($signed({instr[31], instr[19:12],
                                        instr[20], instr[30:21],
                                        1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32/64I decode stage: one-entry registered valid/ready stage.
// Ports: clk, reset (async active-low), in_* upstream handshake and
// instruction/pc, flush, out_* downstream handshake and decoded bundle.
// Macro DECODE_MEXT_EN enables decode of the RV M extension.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ALUCTRL_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [XLEN-1:0]      out_imm,
    output logic [ALUCTRL_W-1:0] out_alu_control,
    output logic [2:0]           out_opclass,
    output logic                 out_reg_write,
    output logic                 out_mem_write,
    output logic                 out_illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;
    logic [4:0] rd_f;

    assign opcode = in_instr[6:0];
    assign rd_f   = in_instr[11:7];
    assign f3     = in_instr[14:12];
    assign rs1_f  = in_instr[19:15];
    assign rs2_f  = in_instr[24:20];
    assign f7     = in_instr[31:25];

    id_ctrl_t        dec;
    imm_fmt_t        fmt;
    logic [XLEN-1:0] imm_d;

    always_comb begin
        dec = '0;
        fmt = IMM_NONE;
        unique case (1'b1)
            opcode == OP_R: begin
                dec.rs1       = rs1_f;
                dec.rs2       = rs2_f;
                dec.rd        = rd_f;
                dec.opclass   = OC_R;
                dec.reg_write = 1'b1;
                unique case (f7)
                    F7_BASE: dec.alu = alu_arith(f3, 1'b0);
                    F7_ALT: begin
                        if (f3 == 3'b000 || f3 == 3'b101)
                            dec.alu = alu_arith(f3, 1'b1);
                        else
                            dec.illegal = 1'b1;
                    end
`ifdef DECODE_MEXT_EN
                    F7_MEXT: dec.alu = alu_mext(f3);
`else
                    F7_MEXT: dec.illegal = 1'b1;
`endif
                    default: dec.illegal = 1'b1;
                endcase
            end
            opcode == OP_IALU: begin
                dec.rs1       = rs1_f;
                dec.rd        = rd_f;
                dec.opclass   = OC_IALU;
                dec.reg_write = 1'b1;
                // instr[30] only means arithmetic shift for funct3=101
                dec.alu       = alu_arith(f3, f3 == 3'b101 && in_instr[30]);
                fmt           = IMM_I;
            end
            opcode == OP_LOAD: begin
                dec.rs1       = rs1_f;
                dec.rd        = rd_f;
                dec.opclass   = OC_LOAD;
                dec.reg_write = 1'b1;
                dec.alu       = ALU_ADD;
                fmt           = IMM_I;
            end
            opcode == OP_STORE: begin
                dec.rs1       = rs1_f;
                dec.rs2       = rs2_f;
                dec.opclass   = OC_STORE;
                dec.mem_write = 1'b1;
                dec.alu       = ALU_ADD;
                fmt           = IMM_S;
            end
            opcode == OP_BRANCH: begin
                dec.rs1     = rs1_f;
                dec.rs2     = rs2_f;
                dec.opclass = OC_BRANCH;
                dec.alu     = alu_branch(f3);
                fmt         = IMM_B;
            end
            opcode == OP_LUI: begin
                dec.rd        = rd_f;
                dec.opclass   = OC_LUI;
                dec.reg_write = 1'b1;
                dec.alu       = ALU_PASSB;
                fmt           = IMM_U;
            end
            opcode == OP_AUIPC: begin
                dec.rd        = rd_f;
                dec.opclass   = OC_AUIPC;
                dec.reg_write = 1'b1;
                dec.alu       = ALU_ADD;
                fmt           = IMM_U;
            end
            opcode == OP_JAL: begin
                dec.rd        = rd_f;
                dec.opclass   = OC_JAL;
                dec.reg_write = 1'b1;
                dec.alu       = ALU_JAL;
                fmt           = IMM_J;
            end
            opcode == OP_JALR: begin
                dec.rs1       = rs1_f;
                dec.rd        = rd_f;
                dec.opclass   = OC_JAL;
                dec.reg_write = 1'b1;
                dec.alu       = ALU_JALR;
                fmt           = IMM_I;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_write = 1'b0;
        end
        if (dec.rd == 5'd0)
            dec.reg_write = 1'b0;
    end

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm_d)
    );

    id_ctrl_t        ctrl_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic            valid_q;
    logic            take;

    assign in_ready = (!valid_q || out_ready) && !flush;
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (take) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec;
            pc_q    <= in_pc;
            imm_q   <= imm_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign out_rs1         = ctrl_q.rs1;
    assign out_rs2         = ctrl_q.rs2;
    assign out_rd          = ctrl_q.rd;
    assign out_imm         = imm_q;
    assign out_alu_control = ALUCTRL_W'(ctrl_q.alu);
    assign out_opclass     = ctrl_q.opclass;
    assign out_reg_write   = ctrl_q.reg_write;
    assign out_mem_write   = ctrl_q.mem_write;
    assign out_illegal     = ctrl_q.illegal;

endmodule
